// File: rtl/pipe_pkg.sv
// Shared pipeline constants: stall codes, divider window states
// and the per-stage stall bundle used by the stall sequencer.
package pipe_pkg;

    localparam logic [1:0] STALL_ADV   = 2'b00;
    localparam logic [1:0] STALL_FLUSH = 2'b01;
    localparam logic [1:0] STALL_HOLD  = 2'b11;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_BUSY = 1'b1
    } div_state_e;

    typedef struct packed {
        logic [1:0] pc;
        logic [1:0] if_id;
        logic [1:0] id_ex;
        logic [1:0] ex_mem;
        logic [1:0] mem_wb;
    } stall_vec_t;

    function automatic stall_vec_t stall_pat(
        input logic [1:0] pc,
        input logic [1:0] if_id,
        input logic [1:0] id_ex,
        input logic [1:0] ex_mem,
        input logic [1:0] mem_wb
    );
        stall_vec_t v;
        v.pc     = pc;
        v.if_id  = if_id;
        v.id_ex  = id_ex;
        v.ex_mem = ex_mem;
        v.mem_wb = mem_wb;
        return v;
    endfunction

endpackage

// File: rtl/stall_div_timer.sv
// Divider occupancy counter: loads DIV_CYCLES-1 on accept, then
// counts down to zero independently of any other stall source.
module stall_div_timer
    import pipe_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    output logic zero_o
);

    localparam int W = $clog2(DIV_CYCLES);
    localparam logic [W-1:0] LOAD = W'(DIV_CYCLES - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load on accept, otherwise decrement until zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register; reset abandons any divide in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall/flush sequencer for the five-stage core.
// Optional perf counters when STALL_CTRL_PERF_EN is defined.
module stall_ctrl
    import pipe_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ld_use,
    input  logic       br_taken,
    input  logic       div_start,
    input  logic       mem_req,
    input  logic       mem_ready,
    output logic [1:0] stall_pc,
    output logic [1:0] stall_if_id,
    output logic [1:0] stall_id_ex,
    output logic [1:0] stall_ex_mem,
    output logic [1:0] stall_mem_wb,
    output logic       div_busy
`ifdef STALL_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_cnt
`endif
);

    div_state_e state_q;
    div_state_e state_d;
    stall_vec_t st;

    logic mem_wait;
    logic div_hold;
    logic accept;
    logic cnt_zero;
    logic c_mem;
    logic c_div;
    logic c_ld;
    logic c_br;

    assign mem_wait = mem_req & ~mem_ready;
    assign div_hold = ((state_q == ST_RUN) & div_start)
                    | ((state_q == ST_BUSY) & ~cnt_zero);
    assign accept   = (state_q == ST_RUN) & div_start & ~mem_wait;

    // Priority-masked one-hot select of the active stall source.
    assign c_mem = ~rst & mem_wait;
    assign c_div = ~rst & ~mem_wait & div_hold;
    assign c_ld  = ~rst & ~mem_wait & ~div_hold & ld_use;
    assign c_br  = ~rst & ~mem_wait & ~div_hold & ~ld_use & br_taken;

    stall_div_timer #(
        .DIV_CYCLES(DIV_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (accept),
        .zero_o (cnt_zero)
    );

    // Divider window state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Enter BUSY on accept, leave once the counter reaches zero.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (accept)   state_d = ST_BUSY;
            ST_BUSY: if (cnt_zero) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    // Stall code decode from the selected source.
    always_comb begin
        st = stall_pat(STALL_ADV, STALL_ADV, STALL_ADV,
                       STALL_ADV, STALL_ADV);
        unique case (1'b1)
            rst:   st = stall_pat(STALL_FLUSH, STALL_FLUSH,
                                  STALL_FLUSH, STALL_FLUSH,
                                  STALL_FLUSH);
            c_mem: st = stall_pat(STALL_HOLD, STALL_HOLD,
                                  STALL_HOLD, STALL_HOLD,
                                  STALL_FLUSH);
            c_div: st = stall_pat(STALL_HOLD, STALL_HOLD,
                                  STALL_HOLD, STALL_FLUSH,
                                  STALL_ADV);
            c_ld:  st = stall_pat(STALL_HOLD, STALL_HOLD,
                                  STALL_FLUSH, STALL_ADV,
                                  STALL_ADV);
            c_br:  st = stall_pat(STALL_ADV, STALL_FLUSH,
                                  STALL_ADV, STALL_ADV,
                                  STALL_ADV);
            default: ;
        endcase
    end

    assign stall_pc     = st.pc;
    assign stall_if_id  = st.if_id;
    assign stall_id_ex  = st.id_ex;
    assign stall_ex_mem = st.ex_mem;
    assign stall_mem_wb = st.mem_wb;
    assign div_busy     = (state_q == ST_BUSY);

`ifdef STALL_CTRL_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    // Count PC-hold cycles and branch-caused IF/ID flushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (st.pc == STALL_HOLD) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (c_br) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_flush_cnt    = perf_flush_q;
`else
    // No performance counters in this build.
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl with a 4-cycle divider window.
// Perf counter checks are built when STALL_CTRL_PERF_EN is defined.
module tb_stall_ctrl;

    localparam logic [9:0] P_ADV = 10'b00_00_00_00_00;
    localparam logic [9:0] P_RST = 10'b01_01_01_01_01;
    localparam logic [9:0] P_MEM = 10'b11_11_11_11_01;
    localparam logic [9:0] P_DIV = 10'b11_11_11_01_00;
    localparam logic [9:0] P_LD  = 10'b11_11_01_00_00;
    localparam logic [9:0] P_BR  = 10'b00_01_00_00_00;

    typedef struct {
        logic       ld;
        logic       br;
        logic       ds;
        logic       mr;
        logic       my;
        logic [9:0] exp;
        string      nm;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       ld_use;
    logic       br_taken;
    logic       div_start;
    logic       mem_req;
    logic       mem_ready;
    logic [1:0] stall_pc;
    logic [1:0] stall_if_id;
    logic [1:0] stall_id_ex;
    logic [1:0] stall_ex_mem;
    logic [1:0] stall_mem_wb;
    logic       div_busy;
`ifdef STALL_CTRL_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flush_cnt;
`endif

    int checks = 0;
    int errors = 0;
    vec_t v[10];

    stall_ctrl #(
        .DIV_CYCLES(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ld_use       (ld_use),
        .br_taken     (br_taken),
        .div_start    (div_start),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .stall_pc     (stall_pc),
        .stall_if_id  (stall_if_id),
        .stall_id_ex  (stall_id_ex),
        .stall_ex_mem (stall_ex_mem),
        .stall_mem_wb (stall_mem_wb),
        .div_busy     (div_busy)
`ifdef STALL_CTRL_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_cnt    (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [9:0] exp,
                         input logic eb);
        logic [9:0] got;
        got = {stall_pc, stall_if_id, stall_id_ex,
               stall_ex_mem, stall_mem_wb};
        checks++;
        if (got !== exp || div_busy !== eb) begin
            errors++;
            $display("FAIL %s: got stall=%b busy=%b, expected stall=%b busy=%b",
                     nm, got, div_busy, exp, eb);
        end
    endtask

    task automatic cyc(input logic ld, input logic br, input logic ds,
                       input logic mr, input logic my,
                       input logic [9:0] exp, input logic eb,
                       input string nm);
        ld_use    = ld;
        br_taken  = br;
        div_start = ds;
        mem_req   = mr;
        mem_ready = my;
        @(negedge clk);
        check(nm, exp, eb);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        v[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, P_ADV, "idle"};
        v[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, P_LD,  "ld_use"};
        v[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, P_ADV, "after_ld_use"};
        v[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, P_LD,  "ld_use_over_br"};
        v[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, P_BR,  "br_taken"};
        v[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, P_MEM, "mem_wait"};
        v[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, P_ADV, "mem_ready"};
        v[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, P_MEM, "mem_over_ld_br"};
        v[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, P_MEM, "mem_over_div"};
        v[9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, P_BR,  "br_no_accept"};

        rst = 1'b1;
        cyc(0, 0, 0, 0, 0, P_RST, 1'b0, "reset");
        cyc(1, 1, 1, 1, 0, P_RST, 1'b0, "reset_masks");
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            cyc(v[i].ld, v[i].br, v[i].ds, v[i].mr, v[i].my,
                v[i].exp, 1'b0, v[i].nm);
        end

        // Divide held for its whole window.
        cyc(0, 0, 1, 0, 0, P_DIV, 1'b0, "div_c1");
        cyc(0, 0, 1, 0, 0, P_DIV, 1'b1, "div_c2");
        cyc(1, 1, 1, 0, 0, P_DIV, 1'b1, "div_c3_over_ld");
        cyc(0, 0, 1, 0, 0, P_DIV, 1'b1, "div_c4");
        cyc(0, 0, 1, 0, 0, P_ADV, 1'b1, "div_c5_release");
        cyc(0, 0, 0, 0, 0, P_ADV, 1'b0, "div_c6_idle");

        // Memory wait inside the divide window.
        cyc(0, 0, 1, 0, 0, P_DIV, 1'b0, "dm_c1");
        cyc(0, 0, 1, 1, 0, P_MEM, 1'b1, "dm_c2_mem");
        cyc(0, 0, 1, 1, 0, P_MEM, 1'b1, "dm_c3_mem");
        cyc(0, 0, 1, 1, 0, P_MEM, 1'b1, "dm_c4_mem");
        cyc(0, 0, 1, 0, 0, P_ADV, 1'b1, "dm_c5_release");
        cyc(0, 0, 0, 0, 0, P_ADV, 1'b0, "dm_c6_idle");

        // Reset while BUSY abandons the divide.
        cyc(0, 0, 1, 0, 0, P_DIV, 1'b0, "rb_c1");
        cyc(0, 0, 1, 0, 0, P_DIV, 1'b1, "rb_c2");
        rst = 1'b1;
        cyc(0, 0, 1, 0, 0, P_RST, 1'b1, "rb_rst1");
        cyc(0, 0, 1, 0, 0, P_RST, 1'b0, "rb_rst2");
        rst = 1'b0;
        cyc(0, 0, 1, 0, 0, P_DIV, 1'b0, "rb_reaccept");
        cyc(0, 0, 0, 0, 0, P_DIV, 1'b1, "rb_hold_c2");
        cyc(0, 0, 0, 0, 0, P_DIV, 1'b1, "rb_hold_c3");
        cyc(0, 0, 0, 0, 0, P_DIV, 1'b1, "rb_hold_c4");
        cyc(0, 0, 0, 0, 0, P_ADV, 1'b1, "rb_release");
        cyc(0, 0, 0, 0, 0, P_ADV, 1'b0, "rb_idle");

        // Fresh reset, then a 4-cycle divide and two taken branches.
        rst = 1'b1;
        cyc(0, 0, 0, 0, 0, P_RST, 1'b0, "pf_reset");
        rst = 1'b0;
        cyc(0, 0, 1, 0, 0, P_DIV, 1'b0, "pf_div1");
        cyc(0, 0, 1, 0, 0, P_DIV, 1'b1, "pf_div2");
        cyc(0, 0, 1, 0, 0, P_DIV, 1'b1, "pf_div3");
        cyc(0, 0, 1, 0, 0, P_DIV, 1'b1, "pf_div4");
        cyc(0, 0, 0, 0, 0, P_ADV, 1'b1, "pf_release");
        cyc(0, 1, 0, 0, 0, P_BR,  1'b0, "pf_br1");
        cyc(0, 1, 0, 0, 0, P_BR,  1'b0, "pf_br2");
        cyc(0, 0, 0, 0, 0, P_ADV, 1'b0, "pf_idle");
`ifdef STALL_CTRL_PERF_EN
        checks++;
        if (perf_stall_cycles !== 32'd4) begin
            errors++;
            $display("FAIL perf_stall_cycles: got %0d, expected 4",
                     perf_stall_cycles);
        end
        checks++;
        if (perf_flush_cnt !== 32'd2) begin
            errors++;
            $display("FAIL perf_flush_cnt: got %0d, expected 2",
                     perf_flush_cnt);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
